// File: rtl/ping_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ping_burst: ultrasonic ping burst, ring-down blanking, echo time-of-flight |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ping_burst #(
  parameter int HALF_PERIOD = 600,
  parameter int PULSES      = 8,
  parameter int BLANK       = 1200,
  parameter int LISTEN      = 60000,
  parameter int HOLDOFF     = 48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sig,
  output logic        ping_out,
  output logic        trig,
  output logic [15:0] rx_counter,
  output logic        rx_valid,
  output logic        timeout,
  output logic        busy
);

  localparam logic [31:0] HALF_LAST    = 32'(HALF_PERIOD - 1);
  localparam logic [31:0] HALVES_LAST  = 32'(2 * PULSES - 1);
  localparam logic [31:0] BLANK_LAST   = (BLANK > 0) ? 32'(BLANK - 1) : 32'd0;
  localparam logic [31:0] LISTEN_LAST  = 32'(LISTEN - 1);
  localparam logic [31:0] HOLDOFF_LAST = (HOLDOFF > 0) ? 32'(HOLDOFF - 1) : 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BURST   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LISTEN  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] half;
  logic [15:0] tof;
  logic        s1;
  logic        s2;
  logic        s3;
  logic        echo;

  // Rising edge of the synchronized comparator; latency is deliberately not compensated.
  assign echo = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      half       <= '0;
      tof        <= '0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      ping_out   <= 1'b0;
      trig       <= 1'b0;
      rx_counter <= '0;
      rx_valid   <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      s1       <= sig;
      s2       <= s1;
      s3       <= s2;
      trig     <= 1'b0;
      rx_valid <= 1'b0;
      timeout  <= 1'b0;

      if ((state == ST_BURST || state == ST_BLANK || state == ST_LISTEN) && tof != 16'hFFFF)
        tof <= tof + 16'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_BURST;
            busy     <= 1'b1;
            trig     <= 1'b1;
            ping_out <= 1'b1;
            tof      <= '0;
            cnt      <= '0;
            half     <= '0;
          end
        end

        ST_BURST: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (half == HALVES_LAST) begin
              half     <= '0;
              ping_out <= 1'b0;
              state    <= (BLANK == 0) ? ST_LISTEN : ST_BLANK;
            end else begin
              half     <= half + 32'd1;
              ping_out <= ~ping_out;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= ST_LISTEN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_LISTEN: begin
          // An echo on the final listen cycle wins over the timeout.
          if (echo || cnt == LISTEN_LAST) begin
            rx_counter <= echo ? tof : 16'hFFFF;
            rx_valid   <= echo;
            timeout    <= ~echo;
            cnt        <= '0;
            if (HOLDOFF == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_HOLDOFF;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_HOLDOFF: begin
          if (cnt == HOLDOFF_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          ping_out <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ping_burst.md
PING_BURST -- requirements
Module: ping_burst

Interface
REQ-001 Parameter HALF_PERIOD, 600, clk cycles per ping half-period (40 kHz tone at 48 MHz clk); SHALL be >= 1.
REQ-002 Parameter PULSES, 8, ping periods per burst; SHALL be >= 1.
REQ-003 Parameter BLANK, 1200, post-burst cycles in which sig is ignored (ring-down); 0 SHALL skip the BLANK state.
REQ-004 Parameter LISTEN, 60000, cycles in which an echo is accepted; SHALL be >= 1.
REQ-005 Parameter HOLDOFF, 48000, dead cycles before the next start is accepted; 0 SHALL return directly to IDLE.
REQ-006 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  synchronous request for one ping cycle.
REQ-009 sig  in  1  asynchronous 1-bit comparator (LVDS) echo input.
REQ-010 ping_out  out  1  registered transducer drive.
REQ-011 trig  out  1  one-cycle capture trigger to the downstream dump stage.
REQ-012 rx_counter  out  16  time-of-flight in clk cycles, held until the next result.
REQ-013 rx_valid  out  1  one-cycle pulse when rx_counter is updated by an echo.
REQ-014 timeout  out  1  one-cycle pulse when LISTEN expires with no echo.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, BURST, BLANK, LISTEN and HOLDOFF.
REQ-017 In IDLE, start=1 at a clock edge SHALL enter BURST on the next cycle; start SHALL be ignored in all other states (no queuing).
REQ-018 The first BURST cycle SHALL have trig=1, ping_out=1 and tof=0; trig SHALL be 0 in every other cycle.
REQ-019 BURST SHALL last exactly 2*PULSES*HALF_PERIOD cycles, with ping_out=1 in the first HALF_PERIOD cycles of each period and 0 in the second.
REQ-020 ping_out SHALL be 0 in all states except BURST.
REQ-021 The internal 16-bit tof counter SHALL increment by 1 per cycle in BURST, BLANK and LISTEN, and SHALL saturate at 16'hFFFF (no wrap).
REQ-022 After BURST, the block SHALL spend BLANK cycles in BLANK and then LISTEN cycles in LISTEN.
REQ-023 sig SHALL pass a 2-flop synchronizer (s1, s2) and a third register s3; echo = s2 & ~s3.
REQ-024 An echo is an event in any state; only an echo in a LISTEN cycle SHALL be acted on. An echo in BURST, BLANK, HOLDOFF or IDLE SHALL be ignored.
REQ-025 On an accepted echo: rx_counter <= tof of that cycle, rx_valid=1 for one cycle, next state HOLDOFF. The 2-cycle synchronizer latency SHALL NOT be compensated.
REQ-026 If LISTEN ends without an echo: rx_counter <= 16'hFFFF, timeout=1 for one cycle, next state HOLDOFF.
REQ-027 An echo in the final LISTEN cycle SHALL take priority over timeout; rx_valid and timeout SHALL never be high in the same cycle.
REQ-028 HOLDOFF SHALL last HOLDOFF cycles and then return to IDLE; start in the first IDLE cycle SHALL be accepted.

Reset
REQ-029 Asserting rst low SHALL immediately and asynchronously set: state=IDLE, ping_out=0, trig=0, rx_valid=0, timeout=0, busy=0, rx_counter=0, tof=0, s1/s2/s3=0, all sub-counters 0.
REQ-030 A reset asserted mid-burst SHALL drop ping_out within the same cycle, with no partial result reported.
REQ-031 After rst is deasserted, the first start SHALL be accepted on the first rising clk edge at which rst is high.

Verification (HALF_PERIOD=4, PULSES=2, BLANK=8, LISTEN=100, HOLDOFF=10)
REQ-032 Single start pulse -> trig high for 1 cycle; ping_out pattern 1111000011110000 over 16 cycles, then 0; busy high for 16+8+100+10=134 cycles on a timeout run.
REQ-033 sig raised during the cycle with tof=38 -> rx_valid pulse with rx_counter=40; state enters HOLDOFF; no timeout pulse.
REQ-034 sig high only during tof=5..20 (BURST/BLANK) and low afterwards -> no rx_valid; timeout pulse at the end of LISTEN; rx_counter=16'hFFFF.
REQ-035 start held high continuously -> exactly one burst per 134-cycle run plus one IDLE cycle; no start during busy begins a new burst.
REQ-036 rst pulled low at tof=6 -> ping_out, busy and rx_counter read 0 before the next clk edge; after release, start gives a clean burst with trig and tof=0.
REQ-037 Echo in the last LISTEN cycle (sig raised at tof=121) -> rx_valid with rx_counter=123 and no timeout pulse.
